// File: rtl/instruction_fetch.sv
// Fetch stage: owns the program counter, addresses the combinational instruction
// memory and registers each fetched word with its PC into a one-entry output slot.
module instruction_fetch #(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        en,
   output logic [63:0] imem_pc,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [63:0] out_pc,
   output logic        fault
);

   typedef enum logic {RUN, FAULT} state_t;

   state_t      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic        valid_q, valid_d;
   logic [31:0] instr_q, instr_d;
   logic [63:0] opc_q, opc_d;
   logic        slot_free;

   assign slot_free = !valid_q || out_ready;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         valid_q <= 1'b0;
         instr_q <= 32'h0;
         opc_q   <= 64'h0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
         instr_q <= instr_d;
         opc_q   <= opc_d;
      end
   end

   // A redirect always wins over capture and discards the word sitting in the slot.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      instr_d = instr_q;
      opc_d   = opc_q;
      if (state_q == RUN) begin
         if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            state_d = FAULT;
            valid_d = 1'b0;
         end else if (redirect_valid) begin
            pc_d    = redirect_pc;
            valid_d = 1'b0;
         end else if (en && slot_free) begin
            instr_d = imem_instr;
            opc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 64'd4;
         end else if (out_ready) begin
            valid_d = 1'b0;
         end
      end else begin
         valid_d = 1'b0;
      end
   end

   assign imem_pc   = pc_q;
   assign out_valid = valid_q;
   assign out_instr = instr_q;
   assign out_pc    = opc_q;
   assign fault     = (state_q == FAULT);

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        en = 1'b0;
   logic [63:0] imem_pc;
   logic [31:0] imem_instr;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_pc = 64'h0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [63:0] out_pc;
   logic        fault;

   int checks = 0;
   int errors = 0;

   logic [31:0] rom [5];

   // Model state: next fetch address, contents of the output slot, fault flag.
   logic [63:0] m_pc;
   logic        m_valid;
   logic [31:0] m_instr;
   logic [63:0] m_opc;
   logic        m_fault;

   always #5 clk = ~clk;

   function automatic logic [31:0] imem_word(input logic [63:0] a);
      logic [63:0] idx;
      idx = a >> 2;
      if (idx < 64'd5) return rom[idx[2:0]];
      return a[31:0] ^ 32'h5A5A_C3C3 ^ a[63:32];
   endfunction

   assign imem_instr = imem_word(imem_pc);

   instruction_fetch #(.RESET_PC(64'h0)) dut (
      .clk(clk), .rstn(rstn), .en(en), .imem_pc(imem_pc), .imem_instr(imem_instr),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_pc(out_pc), .fault(fault)
   );

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 64'h0; m_valid = 1'b0; m_instr = 32'h0; m_opc = 64'h0; m_fault = 1'b0;
   endtask

   task automatic check_all();
      checkOutput("out_valid", {63'h0, out_valid}, {63'h0, m_valid});
      checkOutput("fault", {63'h0, fault}, {63'h0, m_fault});
      checkOutput("imem_pc", imem_pc, m_pc);
      if (m_valid) begin
         checkOutput("out_instr", {32'h0, out_instr}, {32'h0, m_instr});
         checkOutput("out_pc", out_pc, m_opc);
      end
   endtask

   // Drive one cycle of inputs, advance the model by one edge, then compare.
   task automatic applyStimulus(input logic e, input logic rdy, input logic rv, input logic [63:0] rpc);
      en = e; out_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
      if (m_fault) begin
         m_valid = 1'b0;
      end else if (rv && (rpc % 64'd4 != 64'd0)) begin
         m_fault = 1'b1; m_valid = 1'b0;
      end else if (rv) begin
         m_pc = rpc; m_valid = 1'b0;
      end else if (e && (!m_valid || rdy)) begin
         m_instr = imem_word(m_pc); m_opc = m_pc; m_valid = 1'b1; m_pc = m_pc + 64'd4;
      end else if (rdy) begin
         m_valid = 1'b0;
      end
      @(negedge clk);
      check_all();
   endtask

   task automatic do_reset();
      en = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'h0;
      rstn = 1'b0;
      model_reset();
      @(negedge clk);
      check_all();
      checkOutput("rst_out_instr", {32'h0, out_instr}, 64'h0);
      checkOutput("rst_out_pc", out_pc, 64'h0);
      rstn = 1'b1;
   endtask

   initial begin
      rom[0] = 32'h00106433; rom[1] = 32'h0020e4b3; rom[2] = 32'h0020f533;
      rom[3] = 32'h003175b3; rom[4] = 32'h00000633;
      model_reset();
      @(negedge clk);

      $display("[TB] streaming after reset");
      do_reset();
      for (int k = 0; k < 5; k++) begin
         checkOutput("t1_imem_pc", imem_pc, 64'(4 * k));
         applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
         checkOutput("t1_instr", {32'h0, out_instr}, {32'h0, rom[k]});
         checkOutput("t1_pc", out_pc, 64'(4 * k));
      end

      $display("[TB] backpressure");
      do_reset();
      for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
         checkOutput("t2_hold_instr", {32'h0, out_instr}, 64'h0020f533);
         checkOutput("t2_hold_pc", imem_pc, 64'd12);
      end
      applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
      checkOutput("t2_resume_pc", out_pc, 64'd12);

      $display("[TB] aligned redirect");
      do_reset();
      applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
      applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
      applyStimulus(1'b1, 1'b1, 1'b1, 64'd16);
      checkOutput("t3_flush", {63'h0, out_valid}, 64'h0);
      checkOutput("t3_target", imem_pc, 64'd16);
      applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
      checkOutput("t3_instr", {32'h0, out_instr}, 64'h00000633);
      checkOutput("t3_pc", out_pc, 64'd16);

      $display("[TB] misaligned redirect");
      applyStimulus(1'b1, 1'b1, 1'b1, 64'h6);
      checkOutput("t4_fault", {63'h0, fault}, 64'h1);
      for (int k = 0; k < 10; k++)
         applyStimulus(1'($urandom_range(1)), 1'b1, 1'($urandom_range(1)), 64'($urandom) & ~64'h3);
      do_reset();
      checkOutput("t4_cleared", {63'h0, fault}, 64'h0);
      checkOutput("t4_pc", imem_pc, 64'h0);

      $display("[TB] pc wrap");
      applyStimulus(1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
      applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
      checkOutput("t5_last_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
      checkOutput("t5_wrap", imem_pc, 64'h0);

      $display("[TB] asynchronous reset");
      for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
      @(posedge clk);
      #2;
      rstn = 1'b0;
      #1;
      model_reset();
      check_all();
      en = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      check_all();

      $display("[TB] random traffic");
      for (int k = 0; k < 400; k++) begin
         logic        rv;
         logic [63:0] tgt;
         rv  = ($urandom_range(15) == 0);
         tgt = 64'($urandom_range(15)) << 2;
         if ($urandom_range(7) == 0) tgt = tgt | 64'($urandom_range(3));
         if ($urandom_range(15) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 | (tgt & 64'hC);
         applyStimulus(1'($urandom_range(3) != 0), 1'($urandom_range(2) != 0), rv, tgt);
         if (m_fault && ($urandom_range(7) == 0)) do_reset();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
